// File: rtl/vga_text_pkg.sv
// Shared constants, control codes and state encoding for the 80x25 text display
// and the character-stream writer that feeds it.
package vga_text_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 25;
    localparam int ADDR_W = 11;

    localparam logic [7:0] GLYPH_OFFSET = 8'd1;
    localparam logic [7:0] BLANK_CHAR   = 8'h20;
    localparam logic [7:0] BLANK_GLYPH  = BLANK_CHAR + GLYPH_OFFSET;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_ROW,
        CLEAR_ALL
    } state_t;

    // First cell address of a row; the largest result (24*80) fits in ADDR_W bits.
    function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] row);
        return ADDR_W'(row) * ADDR_W'(COLS);
    endfunction

endpackage

// File: rtl/text_buffer_writer_if.sv
// Byte-stream input handshake plus character-RAM write port of the text writer.
interface text_buffer_writer_if;
    import vga_text_pkg::*;

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface

// File: rtl/text_buffer_writer.sv
// Turns a byte stream into character-RAM writes for the text display, tracking
// the cursor, interpreting CR/LF/BS/FF and blanking rows as the cursor wraps.
module text_buffer_writer
    import vga_text_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    text_buffer_writer_if.slave    bus,
    output logic [4:0]             cursor_row,
    output logic [6:0]             cursor_col,
    output logic                   busy
);

    localparam logic [6:0]        COL_LAST   = 7'(COLS - 1);
    localparam logic [4:0]        ROW_LAST   = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_CLR_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ALL_CLR_LAST = ADDR_W'(COLS * ROWS - 1);

    state_t            state, state_next;
    logic [4:0]        row, row_next;
    logic [6:0]        col, col_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic              wr_en_q, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_next;
    logic [7:0]        wr_data_q, wr_data_next;
    logic              accept;
    logic              start_newline;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR_ALL;
            row       <= '0;
            col       <= '0;
            cnt       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state     <= state_next;
            row       <= row_next;
            col       <= col_next;
            cnt       <= cnt_next;
            wr_en_q   <= wr_en_next;
            wr_addr_q <= wr_addr_next;
            wr_data_q <= wr_data_next;
        end
    end

    // During CLEAR_ROW the cursor already points at the row being blanked.
    always_comb begin
        state_next    = state;
        row_next      = row;
        col_next      = col;
        cnt_next      = cnt;
        wr_en_next    = 1'b0;
        wr_addr_next  = wr_addr_q;
        wr_data_next  = wr_data_q;
        start_newline = 1'b0;
        accept        = bus.in_valid && (state == IDLE);

        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.in_data >= PRINT_MIN && bus.in_data <= PRINT_MAX) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = row_base(row) + ADDR_W'(col);
                        wr_data_next = bus.in_data + GLYPH_OFFSET;
                        if (col < COL_LAST) begin
                            col_next = col + 7'd1;
                        end else begin
                            start_newline = 1'b1;
                        end
                    end else if (bus.in_data == CH_CR) begin
                        col_next = '0;
                    end else if (bus.in_data == CH_LF) begin
                        start_newline = 1'b1;
                    end else if (bus.in_data == CH_BS) begin
                        if (col != '0) begin
                            col_next     = col - 7'd1;
                            wr_en_next   = 1'b1;
                            wr_addr_next = row_base(row) + ADDR_W'(col - 7'd1);
                            wr_data_next = BLANK_GLYPH;
                        end
                    end else if (bus.in_data == CH_FF) begin
                        row_next   = '0;
                        col_next   = '0;
                        cnt_next   = '0;
                        state_next = CLEAR_ALL;
                    end
                end

                if (start_newline) begin
                    col_next   = '0;
                    row_next   = (row == ROW_LAST) ? 5'd0 : row + 5'd1;
                    cnt_next   = '0;
                    state_next = CLEAR_ROW;
                end
            end

            CLEAR_ROW: begin
                wr_en_next   = 1'b1;
                wr_addr_next = row_base(row) + cnt;
                wr_data_next = BLANK_GLYPH;
                if (cnt == ROW_CLR_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + ADDR_W'(1);
                end
            end

            CLEAR_ALL: begin
                wr_en_next   = 1'b1;
                wr_addr_next = cnt;
                wr_data_next = BLANK_GLYPH;
                if (cnt == ALL_CLR_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + ADDR_W'(1);
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = (state != IDLE);
    assign cursor_row   = row;
    assign cursor_col   = col;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Randomized scoreboard bench for text_buffer_writer: a screen-level model queues
// the expected character-RAM writes and a monitor matches every wr_en pulse.
module tb_text_buffer_writer;
    import vga_text_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;
    logic       busy;

    text_buffer_writer_if bus();

    text_buffer_writer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int write_total = 0;

    logic [18:0] exp_q[$];
    int model_row = 0;
    int model_col = 0;
    int model_clear_len = 0;

    task automatic checkValue(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void pushWrite(input int addr, input int data);
        exp_q.push_back({11'(addr), 8'(data)});
    endfunction

    function automatic void modelClearScreen();
        for (int i = 0; i < 80 * 25; i++) pushWrite(i, 8'h21);
        model_clear_len = 80 * 25;
    endfunction

    function automatic void modelNewline();
        model_col = 0;
        model_row = (model_row + 1) % 25;
        for (int i = 0; i < 80; i++) pushWrite(model_row * 80 + i, 8'h21);
        model_clear_len = 80;
    endfunction

    // Screen-level behaviour of one accepted byte.
    function automatic void modelByte(input logic [7:0] b);
        model_clear_len = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            pushWrite(model_row * 80 + model_col, int'(b) + 1);
            if (model_col < 79) model_col++;
            else modelNewline();
        end else if (b == 8'h0D) begin
            model_col = 0;
        end else if (b == 8'h0A) begin
            modelNewline();
        end else if (b == 8'h08) begin
            if (model_col > 0) begin
                model_col--;
                pushWrite(model_row * 80 + model_col, 8'h21);
            end
        end else if (b == 8'h0C) begin
            model_row = 0;
            model_col = 0;
            modelClearScreen();
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.wr_en) begin
            write_total++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %0d, expected no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                checkValue("wr_addr", int'(bus.wr_addr), int'(e[18:8]));
                checkValue("wr_data", int'(bus.wr_data), int'(e[7:0]));
            end
        end
    end

    // Holds the byte on the bus until the writer takes it, then updates the model.
    task automatic applyStimulus(input logic [7:0] b);
        int waited;
        bit done;
        waited = 0;
        done   = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!done) begin
            if (bus.in_ready) begin
                @(posedge clk);
                modelByte(b);
                done = 1;
            end else if (waited > 5000) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL accept_timeout: got no in_ready in %0d cycles, expected acceptance", waited);
                done = 1;
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic waitReady(input int expected_low);
        int low;
        low = 0;
        while (!bus.in_ready && low < 5000) begin
            low++;
            @(negedge clk);
        end
        checkValue("in_ready_low_cycles", low, expected_low);
    endtask

    task automatic checkOutput();
        @(negedge clk);
        checkValue("cursor_row", int'(cursor_row), model_row);
        checkValue("cursor_col", int'(cursor_col), model_col);
        checkValue("in_ready", int'(bus.in_ready), (model_clear_len == 0) ? 1 : 0);
        checkValue("busy", int'(busy), (model_clear_len == 0) ? 0 : 1);
        if (model_clear_len != 0) waitReady(model_clear_len);
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(b);
        checkOutput();
    endtask

    task automatic sendPrintable();
        sendByte(8'($urandom_range(32, 126)));
    endtask

    initial begin
        int base;
        int guard;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        modelClearScreen();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkValue("reset_wr_en", int'(bus.wr_en), 0);
        checkValue("reset_wr_addr", int'(bus.wr_addr), 0);
        checkValue("reset_wr_data", int'(bus.wr_data), 0);
        checkValue("reset_in_ready", int'(bus.in_ready), 0);
        checkValue("reset_cursor_row", int'(cursor_row), 0);
        checkValue("reset_cursor_col", int'(cursor_col), 0);
        waitReady(2000);

        sendByte(8'h41);

        sendByte(8'h0D);
        repeat (3) sendByte(8'h0A);
        repeat (79) sendPrintable();
        sendByte(8'h5A);

        while (model_row != 24) sendByte(8'h0A);
        sendByte(8'h0A);

        repeat (2) sendByte(8'h0A);
        sendByte(8'h0D);
        repeat (5) sendPrintable();
        sendByte(8'h08);
        sendByte(8'h0D);
        sendByte(8'h08);
        sendByte(8'h0D);

        while (model_row != 10) sendByte(8'h0A);
        sendByte(8'h0D);
        repeat (40) sendPrintable();
        applyStimulus(8'h0C);
        base = write_total;
        fork
            applyStimulus(8'h51);
            begin
                guard = 0;
                while (write_total < base + 500 && guard < 5000) begin
                    @(negedge clk);
                    #1;
                    guard++;
                end
                rst = 1'b1;
                exp_q.delete();
                model_row = 0;
                model_col = 0;
                modelClearScreen();
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        checkOutput();

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 1) sendPrintable();
            else sendByte(8'($urandom_range(0, 255)));
        end

        repeat (5) @(negedge clk);
        checkValue("pending_writes", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
